// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch stage and the instruction decoder:
//   - CPU_ADDR_W / CPU_INSTR_W : default address and instruction widths
//   - opcode_e                 : 4-bit opcode field (instruction bits [15:12])
//   - NOP_INSTR                : bubble instruction presented on squashed slots
//   - fetch_state_e            : fetch FSM state encoding
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_ADDR_W  = 5;
    localparam int CPU_INSTR_W = 16;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_LD  = 4'b0101,
        OP_ST  = 4'b0110,
        OP_LDI = 4'b0111,
        OP_BEQ = 4'b1000,
        OP_BNE = 4'b1001,
        OP_NOP = 4'b1010,
        OP_JMP = 4'b1111
    } opcode_e;

    localparam logic [CPU_INSTR_W-1:0] NOP_INSTR = {OP_NOP, 12'h000};

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_mem.sv
// ----------------------------------------------------------------------------
// instr_mem
// IM_DEPTH x INSTR_W register-array instruction memory. Contents are not
// reset, so a program survives a reset of the fetch stage.
// Ports:
//   clk    in  clock, rising edge
//   we     in  write enable (already qualified by the caller)
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  asynchronous read address
//   rdata  out read data, combinational from raddr
// ----------------------------------------------------------------------------
module instr_mem
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int INSTR_W  = CPU_INSTR_W,
    parameter int IM_DEPTH = 2**ADDR_W
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [IM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage feeding the decoder. Holds the program counter and a
// writable instruction memory, and presents one registered instruction per
// cycle. A taken jump from the decoder squashes the wrong-path fetch and
// inserts exactly one NOP bubble.
//
// Build option: define FETCH_HALT_ON_WRAP_EN to stop in a HALT state after the
// instruction at the last memory address has been delivered, instead of
// wrapping the PC back to 0.
//
// Ports:
//   CLK       in  clock, rising edge
//   RST       in  asynchronous active-low reset
//   START     in  leave IDLE and fetch from RESET_PC
//   STALL     in  freeze PC / IF_INSTR / IF_VALID this cycle
//   JMP       in  taken-jump request from the decoder
//   JMP_ADDR  in  jump target
//   IM_WE     in  instruction memory write enable (IDLE only)
//   IM_WADDR  in  write address
//   IM_WDATA  in  write data
//   IF_INSTR  out registered instruction to the decoder
//   IF_VALID  out IF_INSTR is a real fetch, not a bubble
//   PC        out address of the next fetch
//   BUSY      out high in RUN
//   HALTED    out high in HALT (always 0 without FETCH_HALT_ON_WRAP_EN)
// ----------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                INSTR_W  = CPU_INSTR_W,
    parameter int                IM_DEPTH = 2**ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               STALL,
    input  logic               JMP,
    input  logic [ADDR_W-1:0]  JMP_ADDR,
    input  logic               IM_WE,
    input  logic [ADDR_W-1:0]  IM_WADDR,
    input  logic [INSTR_W-1:0] IM_WDATA,
    output logic [INSTR_W-1:0] IF_INSTR,
    output logic               IF_VALID,
    output logic [ADDR_W-1:0]  PC,
    output logic               BUSY,
    output logic               HALTED
);

    localparam logic [1:0] ST_IDLE = FS_IDLE;
    localparam logic [1:0] ST_RUN  = FS_RUN;
`ifdef FETCH_HALT_ON_WRAP_EN
    localparam logic [1:0] ST_HALT = FS_HALT;
`endif

    logic [1:0]         state;
    logic [ADDR_W-1:0]  pc_p0;
    logic [INSTR_W-1:0] instr_p1;
    logic               vld_p1;

    logic [INSTR_W-1:0] rd_data;
    logic               im_we_idle;
    logic [ADDR_W-1:0]  pc_inc;

    // Programming is only allowed while the stage is not fetching.
    assign im_we_idle = IM_WE && (state == ST_IDLE);
    assign pc_inc     = pc_p0 + ADDR_W'(1);

`ifdef FETCH_HALT_ON_WRAP_EN
    logic at_last;
    assign at_last = (pc_p0 == ADDR_W'(IM_DEPTH - 1));
`endif

    instr_mem #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .IM_DEPTH (IM_DEPTH)
    ) u_imem (
        .clk   (CLK),
        .we    (im_we_idle),
        .waddr (IM_WADDR),
        .wdata (IM_WDATA),
        .raddr (pc_p0),
        .rdata (rd_data)
    );

    // p0 -> p1: PC addresses the memory, the read word is registered out
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_IDLE;
            pc_p0    <= RESET_PC;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state <= ST_RUN;
                        pc_p0 <= RESET_PC;
                    end
                end
                ST_RUN: begin
                    // A stalled cycle ignores JMP; the decoder re-raises it
                    // because IF_INSTR is held.
                    if (!STALL) begin
                        if (JMP && vld_p1) begin
                            // Squash the wrong-path fetch: one bubble.
                            pc_p0    <= JMP_ADDR;
                            instr_p1 <= NOP_INSTR;
                            vld_p1   <= 1'b0;
                        end else begin
                            instr_p1 <= rd_data;
                            vld_p1   <= 1'b1;
`ifdef FETCH_HALT_ON_WRAP_EN
                            // Last word is still delivered; PC stays on it.
                            if (at_last) begin
                                state <= ST_HALT;
                            end else begin
                                pc_p0 <= pc_inc;
                            end
`else
                            pc_p0 <= pc_inc;
`endif
                        end
                    end
                end
`ifdef FETCH_HALT_ON_WRAP_EN
                ST_HALT: begin
                    instr_p1 <= NOP_INSTR;
                    vld_p1   <= 1'b0;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign IF_INSTR = instr_p1;
    assign IF_VALID = vld_p1;
    assign PC       = pc_p0;
    assign BUSY     = (state == ST_RUN);
`ifdef FETCH_HALT_ON_WRAP_EN
    assign HALTED   = (state == ST_HALT);
`else
    assign HALTED   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'hA000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        STALL = 1'b0;
    logic        JMP = 1'b0;
    logic [4:0]  JMP_ADDR = '0;
    logic        IM_WE = 1'b0;
    logic [4:0]  IM_WADDR = '0;
    logic [15:0] IM_WDATA = '0;
    logic [15:0] IF_INSTR;
    logic        IF_VALID;
    logic [4:0]  PC;
    logic        BUSY;
    logic        HALTED;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK(CLK), .RST(RST), .START(START), .STALL(STALL), .JMP(JMP),
        .JMP_ADDR(JMP_ADDR), .IM_WE(IM_WE), .IM_WADDR(IM_WADDR), .IM_WDATA(IM_WDATA),
        .IF_INSTR(IF_INSTR), .IF_VALID(IF_VALID), .PC(PC), .BUSY(BUSY), .HALTED(HALTED)
    );

    // Reference model: program image plus architectural view of the stage.
    logic [15:0] m_mem [32];
    int          m_pc;
    logic [15:0] m_instr;
    logic        m_valid;
    int          m_mode;   // 0 idle, 1 fetching, 2 halted

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] prog [4] = '{16'h0101, 16'h1202, 16'h2303, 16'h3404};
    logic [23:0] dut_vec;
    assign dut_vec = {BUSY, HALTED, IF_VALID, PC, IF_INSTR};

    function automatic logic [23:0] exp_vec();
        logic [4:0] p;
        p = 5'(m_pc);
        return {m_mode == 1, m_mode == 2, m_valid, p, m_instr};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        START = 1'b0; STALL = 1'b0; JMP = 1'b0; JMP_ADDR = '0;
        IM_WE = 1'b0; IM_WADDR = '0; IM_WDATA = '0;
    endtask

    // Advance the model by the rules for this cycle's inputs, then clock the DUT.
    task automatic cycle();
        if (m_mode == 0) begin
            if (IM_WE) m_mem[IM_WADDR] = IM_WDATA;
            if (START) begin m_mode = 1; m_pc = 0; end
        end else if (m_mode == 1) begin
            if (!STALL) begin
                if (JMP && m_valid) begin
                    m_pc = int'(JMP_ADDR); m_instr = NOP; m_valid = 1'b0;
                end else begin
                    m_instr = m_mem[m_pc]; m_valid = 1'b1;
`ifdef FETCH_HALT_ON_WRAP_EN
                    if (m_pc == 31) m_mode = 2;
                    else m_pc = (m_pc + 1) % 32;
`else
                    m_pc = (m_pc + 1) % 32;
`endif
                end
            end
        end else begin
            m_instr = NOP; m_valid = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b0;
        #2;
        RST = 1'b1;
        model_reset();
    endtask

    task automatic load(input int a, input logic [15:0] d);
        IM_WE = 1'b1; IM_WADDR = 5'(a); IM_WDATA = d;
        cycle();
        IM_WE = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge CLK); #1;
        idle_inputs();
        RST = 1'b0;
        #2;
        model_reset();
        n_cmp++;
        if (dut_vec !== {3'b000, 5'd0, NOP}) begin
            n_bad++; $display("FAIL reset_values: got %h want %h", dut_vec, {3'b000, 5'd0, NOP});
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        // STALL/JMP have no meaning in IDLE.
        STALL = 1'b1; JMP = 1'b1; JMP_ADDR = 5'd9;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== {3'b000, 5'd0, NOP}) begin
                n_bad++; $display("FAIL idle_hold: got %h want %h", dut_vec, {3'b000, 5'd0, NOP});
            end
        end
        idle_inputs();
    endtask

    task automatic test_load_run();
        for (int a = 0; a < 32; a++) begin
            load(a, (a < 4) ? prog[a] : 16'($urandom));
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL load_idle a=%0d: got %h want %h", a, dut_vec, exp_vec());
            end
        end
        START = 1'b1;
        cycle();
        START = 1'b0;
        n_cmp++;
        if (dut_vec !== {3'b100, 5'd0, NOP}) begin
            n_bad++; $display("FAIL start_run: got %h want %h", dut_vec, {3'b100, 5'd0, NOP});
        end
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== {3'b101, 5'(k + 1), prog[k]}) begin
                n_bad++; $display("FAIL seq_fetch k=%0d: got %h want %h", k, dut_vec, {3'b101, 5'(k + 1), prog[k]});
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        load(2, 16'hF050);
        load(10, 16'h7155);
        START = 1'b1; cycle(); START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL jump_pre i=%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (IF_INSTR !== 16'hF050 || PC !== 5'd3) begin
            n_bad++; $display("FAIL jump_src: got %h pc %0d want f050 pc 3", IF_INSTR, PC);
        end
        JMP = 1'b1; JMP_ADDR = 5'd10;
        cycle();
        n_cmp++;
        if (dut_vec !== {3'b100, 5'd10, NOP}) begin
            n_bad++; $display("FAIL jump_bubble: got %h want %h", dut_vec, {3'b100, 5'd10, NOP});
        end
        // JMP during the bubble must be ignored.
        JMP_ADDR = 5'd20;
        cycle();
        JMP = 1'b0;
        n_cmp++;
        if (dut_vec !== {3'b101, 5'd11, 16'h7155}) begin
            n_bad++; $display("FAIL jump_target: got %h want %h", dut_vec, {3'b101, 5'd11, 16'h7155});
        end
    endtask

    task automatic test_stall();
        logic [23:0] snap;
        logic [4:0]  tgt;
        do_reset();
        START = 1'b1; cycle(); START = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL stall_pre i=%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        snap = exp_vec();
        tgt  = 5'($urandom_range(6, 30));
        STALL = 1'b1; JMP = 1'b1; JMP_ADDR = tgt;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== snap || PC !== 5'd5) begin
                n_bad++; $display("FAIL stall_freeze i=%0d: got %h want %h", i, dut_vec, snap);
            end
        end
        STALL = 1'b0;
        cycle();
        JMP = 1'b0;
        n_cmp++;
        if (dut_vec !== {3'b100, tgt, NOP}) begin
            n_bad++; $display("FAIL stall_jump: got %h want %h", dut_vec, {3'b100, tgt, NOP});
        end
        cycle();
        n_cmp++;
        if (IF_INSTR !== m_mem[tgt] || IF_VALID !== 1'b1) begin
            n_bad++; $display("FAIL stall_target: got %h/%b want %h/1", IF_INSTR, IF_VALID, m_mem[tgt]);
        end
    endtask

`ifndef FETCH_HALT_ON_WRAP_EN
    task automatic test_wrap();
        logic [15:0] orig0;
        logic [15:0] orig31;
        int          from;
        orig0  = m_mem[0];
        orig31 = m_mem[31];
        do_reset();
        START = 1'b1; cycle(); START = 1'b0;
        for (int i = 0; i < 34; i++) begin
            // Writes during RUN must not reach the memory.
            IM_WE = 1'b1;
            IM_WADDR = (i % 3 == 0) ? 5'd0 : 5'($urandom);
            IM_WDATA = ~orig0;
            from = m_pc;
            cycle();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL wrap_run i=%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (from == 31) begin
                n_cmp++;
                if (IF_INSTR !== orig31 || PC !== 5'd0) begin
                    n_bad++; $display("FAIL wrap_last: got %h pc %0d want %h pc 0", IF_INSTR, PC, orig31);
                end
            end
            if (i == 32) begin
                n_cmp++;
                if (IF_INSTR !== orig0) begin
                    n_bad++; $display("FAIL wrap_mem0: got %h want %h", IF_INSTR, orig0);
                end
            end
        end
        IM_WE = 1'b0;
    endtask
`else
    task automatic test_halt();
        do_reset();
        START = 1'b1; cycle(); START = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL halt_run i=%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (IF_INSTR !== m_mem[31] || IF_VALID !== 1'b1) begin
            n_bad++; $display("FAIL halt_last: got %h/%b want %h/1", IF_INSTR, IF_VALID, m_mem[31]);
        end
        cycle();
        START = 1'b1; JMP = 1'b1; JMP_ADDR = 5'd4;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut_vec !== {3'b010, 5'd31, NOP}) begin
                n_bad++; $display("FAIL halt_hold i=%0d: got %h want %h", i, dut_vec, {3'b010, 5'd31, NOP});
            end
            cycle();
        end
        do_reset();
        n_cmp++;
        if (dut_vec !== {3'b000, 5'd0, NOP}) begin
            n_bad++; $display("FAIL halt_exit: got %h want %h", dut_vec, {3'b000, 5'd0, NOP});
        end
    endtask
`endif

    task automatic test_reset_mid_run();
        do_reset();
        START = 1'b1; cycle(); START = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
        n_cmp++;
        if (PC !== 5'd7 || BUSY !== 1'b1) begin
            n_bad++; $display("FAIL midrst_pre: got pc %0d busy %b want pc 7 busy 1", PC, BUSY);
        end
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec !== {3'b000, 5'd0, NOP}) begin
            n_bad++; $display("FAIL midrst_async: got %h want %h", dut_vec, {3'b000, 5'd0, NOP});
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        START = 1'b1; cycle(); START = 1'b0;
        cycle();
        n_cmp++;
        if (dut_vec !== {3'b101, 5'd1, m_mem[0]}) begin
            n_bad++; $display("FAIL midrst_restart: got %h want %h", dut_vec, {3'b101, 5'd1, m_mem[0]});
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            START    = ($urandom_range(0, 3) == 0);
            STALL    = ($urandom_range(0, 3) == 0);
            JMP      = (IF_VALID && IF_INSTR[15:12] == 4'hF) || ($urandom_range(0, 7) == 0);
            JMP_ADDR = 5'($urandom);
            IM_WE    = ($urandom_range(0, 1) == 0);
            IM_WADDR = 5'($urandom);
            IM_WDATA = 16'($urandom);
            cycle();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL random i=%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_jump();
        test_stall();
`ifndef FETCH_HALT_ON_WRAP_EN
        test_wrap();
`else
        test_halt();
`endif
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
